// File: rtl/rr_arbiter_8.sv
// ----------------------------------------------------------------------------
// rr_arbiter_8
//
// Eight-way round-robin arbiter for one shared decoded resource. It grants a
// single requester at a time and presents the grant both as a one-hot vector
// and as an index/valid pair that can drive a decoder_3to8 directly. A grant
// is held while its owner keeps requesting, for at most MAX_HOLD cycles when
// other requesters are waiting. Between any two grants there is always one
// cycle with all outputs low, so two selects never overlap on the resource.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles under competition (2..256)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        arbiter enable; low releases the current grant and blocks new ones
//   req[7:0]  level-sensitive request vector, bit i = requester i
//   gnt[7:0]  registered one-hot grant, or all zero
//   gnt_idx   registered index of the current or most recent owner
//   gnt_vld   registered, equal to |gnt
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no owner; grant the next requester found from ptr
// GRANT | gnt_idx owns the resource; hold_cnt counts cycles of ownership
// GAP   | one forced dead cycle after a release; may grant again from ptr
// ----------------------------------------------------------------------------
module rr_arbiter_8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_vld
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [2:0]    ptr;
   logic [2:0]    ptr_nxt;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_nxt;
   logic [7:0]    gnt_nxt;
   logic [2:0]    idx_nxt;
   logic          vld_nxt;

   logic [2:0]    winner;
   logic [2:0]    cand;
   logic          found;
   logic          any_req;
   logic          own_req;
   logic          others_req;

   assign any_req    = |req;
   assign own_req    = req[gnt_idx];
   assign others_req = |(req & ~(8'b1 << gnt_idx));

   // Rotating search: first set request at or above ptr, wrapping 7 -> 0.
   always_comb begin
      winner = ptr;
      cand   = '0;
      found  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cand = ptr + 3'(i);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      gnt_nxt   = gnt;
      idx_nxt   = gnt_idx;
      vld_nxt   = gnt_vld;

      case (state)
         IDLE, GAP: begin
            // IDLE and GAP arbitrate identically; GAP exists only so the
            // released owner's select is low for one full cycle.
            if (en && any_req) begin
               state_nxt = GRANT;
               idx_nxt   = winner;
               gnt_nxt   = 8'b1 << winner;
               vld_nxt   = 1'b1;
               hold_nxt  = '0;
            end else begin
               state_nxt = IDLE;
               gnt_nxt   = 8'h00;
               vld_nxt   = 1'b0;
            end
         end

         GRANT: begin
            if (!own_req || !en || (hold_cnt == HOLD_LAST && others_req)) begin
               state_nxt = GAP;
               gnt_nxt   = 8'h00;
               vld_nxt   = 1'b0;
               ptr_nxt   = gnt_idx + 3'd1;
            end else if (hold_cnt == HOLD_LAST) begin
               // Sole requester: keep the grant and restart the hold window.
               hold_nxt = '0;
            end else begin
               hold_nxt = hold_cnt + HW'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 8'h00;
            vld_nxt   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 3'd0;
         hold_cnt <= '0;
         gnt      <= 8'h00;
         gnt_idx  <= 3'd0;
         gnt_vld  <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
         gnt      <= gnt_nxt;
         gnt_idx  <= idx_nxt;
         gnt_vld  <= vld_nxt;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter_8
//
// Two arbiters (MAX_HOLD = 4 and 16) share one stimulus stream. A reference
// model tracks, per instance, the current owner, how many cycles it has held
// the resource and where the next search starts. Directed vectors, a few
// hand sequences and a randomized phase are all checked against it.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_rr_arbiter_8;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;

   logic [7:0] g4,  g16;
   logic [2:0] i4,  i16;
   logic       v4,  v16;

   int n_cmp = 0;
   int n_bad = 0;

   rr_arbiter_8 #(.MAX_HOLD(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(g4), .gnt_idx(i4), .gnt_vld(v4)
   );

   rr_arbiter_8 #(.MAX_HOLD(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(g16), .gnt_idx(i16), .gnt_vld(v16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int m_owner [2];   // -1 when nobody holds the resource
   int m_last  [2];   // most recent owner
   int m_ptr   [2];   // next search start
   int m_run   [2];   // cycles the current owner has held so far
   int m_mh    [2] = '{4, 16};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_last[k]  = 0;
            m_ptr[k]   = 0;
            m_run[k]   = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (m_owner[k] >= 0) begin
               logic others;
               others = (req & ~8'(1 << m_owner[k])) != 8'h00;
               if (!req[m_owner[k]] || !en || ((m_run[k] % m_mh[k]) == 0 && others)) begin
                  m_ptr[k]   = (m_owner[k] + 1) % 8;
                  m_owner[k] = -1;
               end else begin
                  m_run[k]++;
               end
            end else if (en && req != 8'h00) begin
               bit got;
               got = 1'b0;
               for (int s = 0; s < 8; s++) begin
                  if (!got && req[(m_ptr[k] + s) % 8]) begin
                     m_owner[k] = (m_ptr[k] + s) % 8;
                     got = 1'b1;
                  end
               end
               m_last[k] = m_owner[k];
               m_run[k]  = 1;
            end
         end
      end
   end

   function automatic logic [7:0] m_gnt(input int k);
      return (m_owner[k] >= 0) ? 8'(1 << m_owner[k]) : 8'h00;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("model4_gnt",  g4,  m_gnt(0));
         chk("model4_idx",  8'(i4),  8'(m_last[0]));
         chk("model4_vld",  8'(v4),  8'(m_owner[0] >= 0));
         chk("model16_gnt", g16, m_gnt(1));
         chk("model16_idx", 8'(i16), 8'(m_last[1]));
         chk("model16_vld", 8'(v16), 8'(m_owner[1] >= 0));
         chk("onehot4",     8'($onehot0(g4)),  8'd1);
         chk("onehot16",    8'($onehot0(g16)), 8'd1);
      end
   end

   // ---------------- directed vectors (MAX_HOLD = 4 instance) ----------------
   typedef struct {
      logic       en;
      logic [7:0] req;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       vld;
   } vec_t;

   vec_t tbl [18];

   task automatic do_reset();
      req   = 8'h00;
      en    = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rst_gnt", g4, 8'h00);
      chk("rst_idx", 8'(i4), 8'h00);
      chk("rst_vld", 8'(v4), 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 8'h00;

      //          en    req     gnt    idx   vld
      tbl[0]  = '{1'b1, 8'h08, 8'h08, 3'd3, 1'b1};  // single request
      tbl[1]  = '{1'b1, 8'h00, 8'h00, 3'd3, 1'b0};  // release, ptr -> 4
      tbl[2]  = '{1'b1, 8'h00, 8'h00, 3'd3, 1'b0};
      tbl[3]  = '{1'b1, 8'h81, 8'h80, 3'd7, 1'b1};  // search from 4 finds 7
      tbl[4]  = '{1'b1, 8'h01, 8'h00, 3'd7, 1'b0};  // 7 drops, ptr wraps to 0
      tbl[5]  = '{1'b1, 8'h81, 8'h01, 3'd0, 1'b1};  // one gap, then 0
      tbl[6]  = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b1};
      tbl[7]  = '{1'b0, 8'h01, 8'h00, 3'd0, 1'b0};  // en drop releases
      tbl[8]  = '{1'b0, 8'h05, 8'h00, 3'd0, 1'b0};
      tbl[9]  = '{1'b0, 8'h05, 8'h00, 3'd0, 1'b0};
      tbl[10] = '{1'b1, 8'h05, 8'h04, 3'd2, 1'b1};  // ptr 1 -> 2
      tbl[11] = '{1'b1, 8'h06, 8'h04, 3'd2, 1'b1};
      tbl[12] = '{1'b1, 8'h06, 8'h04, 3'd2, 1'b1};
      tbl[13] = '{1'b1, 8'h06, 8'h04, 3'd2, 1'b1};  // fourth held cycle
      tbl[14] = '{1'b1, 8'h06, 8'h00, 3'd2, 1'b0};  // hold bound hit
      tbl[15] = '{1'b1, 8'h06, 8'h02, 3'd1, 1'b1};  // ptr 3 wraps to 1
      tbl[16] = '{1'b1, 8'h00, 8'h00, 3'd1, 1'b0};
      tbl[17] = '{1'b1, 8'h00, 8'h00, 3'd1, 1'b0};

      do_reset();
      for (int i = 0; i < 18; i++) begin
         en  = tbl[i].en;
         req = tbl[i].req;
         @(negedge clk);
         chk($sformatf("vec%0d_gnt", i), g4, tbl[i].gnt);
         chk($sformatf("vec%0d_idx", i), 8'(i4), 8'(tbl[i].idx));
         chk($sformatf("vec%0d_vld", i), 8'(v4), 8'(tbl[i].vld));
      end

      // Fairness: all requesting, MAX_HOLD = 4 -> 4 cycles each, 1 gap.
      do_reset();
      en  = 1'b1;
      req = 8'hFF;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         chk($sformatf("fair_c%0d", c), g4,
             ((c % 5) < 4) ? 8'(1 << ((c / 5) % 8)) : 8'h00);
      end

      // Sole requester beyond MAX_HOLD keeps the grant without a gap.
      do_reset();
      en  = 1'b1;
      req = 8'h20;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         chk("sole16_gnt", g16, 8'h20);
         chk("sole4_gnt",  g4,  8'h20);
      end

      // Enable drop mid-grant, then re-enable with ptr = 3.
      do_reset();
      en  = 1'b1;
      req = 8'h04;
      @(negedge clk);
      chk("endrop_grant", 8'(i4), 8'd2);
      en  = 1'b0;
      req = 8'h05;
      @(negedge clk);
      chk("endrop_release", g4, 8'h00);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("endrop_blocked", g4, 8'h00);
      end
      en = 1'b1;
      @(negedge clk);
      chk("endrop_regrant_idx", 8'(i4), 8'd0);
      chk("endrop_regrant_gnt", g4, 8'h01);

      // Asynchronous reset between edges during GRANT.
      req = 8'h40;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("arst_pre_gnt", g4, 8'h40);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_gnt", g4,  8'h00);
      chk("arst_vld", 8'(v4), 8'h00);
      chk("arst_gnt16", g16, 8'h00);
      req = 8'h90;
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("arst_regrant_idx", 8'(i4), 8'd4);
      chk("arst_regrant_gnt", g4, 8'h10);

      // Randomized traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 3))
            0: req = req;
            1: req = 8'($urandom);
            2: req = 8'(1 << $urandom_range(0, 7)) | (req & 8'($urandom));
            default: req = req & 8'($urandom);
         endcase
         en = ($urandom_range(0, 15) != 0);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that shares one decoded resource, for example a select line driven by our 3-to-8 decoder, between eight requesters. It picks one requester at a time and drives both a one-hot grant and the matching 3-bit index plus enable, so the index/enable pair can feed a `decoder_3to8` directly. A grant is held while its requester keeps requesting, up to a bounded hold time. A mandatory one-cycle gap between grants guarantees that two selects never overlap on the shared resource.

## Interface
- `MAX_HOLD`, 16: maximum consecutive cycles a grant is held while other requests are pending. Legal range 2..256.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: arbiter enable; when low, no new grant is issued and any current grant is released.
- `req`, input, 8: request vector; bit i is requester i, level-sensitive.
- `gnt`, output, 8: registered one-hot grant, or all zero.
- `gnt_idx`, output, 3: registered index of the current or last granted requester.
- `gnt_vld`, output, 1: registered; high exactly when `gnt` is non-zero, and equal to `|gnt`.

## Operation
- State machine states: IDLE, GRANT, GAP.
- Registers: `ptr[2:0]` (search start), `hold_cnt` (width `$clog2(MAX_HOLD)`), `state`, and the outputs.
- Reset: state = IDLE, `ptr` = 0, `hold_cnt` = 0, `gnt` = 8'h00, `gnt_idx` = 0, `gnt_vld` = 0.
- Winner selection: the first set bit of `req` searching upward from `ptr`, wrapping from 7 to 0.
  - Example: `ptr` = 6, `req` = 8'b0100_0001 selects 6.
  - Example: `ptr` = 7, `req` = 8'b0100_0001 selects 0.
- IDLE:
  - If `en` and `|req`: load `gnt_idx` with the winner, set `gnt` = 1 << winner and `gnt_vld` = 1, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: `hold_cnt` increments each cycle. Exit to GAP when any of the following holds:
  - `req[gnt_idx]` = 0, or
  - `en` = 0, or
  - `hold_cnt` == `MAX_HOLD`-1 while some other `req` bit is set.
- On exit from GRANT: `gnt` = 0, `gnt_vld` = 0, `ptr` = `gnt_idx`+1 mod 8, and `gnt_idx` is retained.
- If `hold_cnt` == `MAX_HOLD`-1 and no other request is pending: `hold_cnt` wraps to 0 and the grant continues.
- GAP: outputs are held at zero for this cycle. The same selection rule runs using the updated `ptr`:
  - If `en` and `|req`: go to GRANT with the new winner.
  - Otherwise go to IDLE.
  - The previous owner may win again only if it is the only requester.
- Simultaneous requests are resolved solely by the `ptr` search order. There is no fixed priority.

## Timing
- Request-to-grant latency: `req` high at rising edge k while in IDLE gives `gnt` valid after edge k (one cycle).
- Release:
  - `req[gnt_idx]` low at edge k drops `gnt` after edge k.
  - The next grant is valid after edge k+1.
  - This gives exactly one dead cycle between grants.
- Hold bound: with competition, one owner holds `gnt` for at most `MAX_HOLD` consecutive cycles.
- All outputs are registered. There is no combinational path from `req` or `en` to any output.
- `rst_n` low at any time, including mid-GRANT, clears all outputs immediately and asynchronously. After deassertion, arbitration restarts from `ptr` = 0.
- `req` bits that drop in the same cycle they are evaluated are not granted. Only the sampled value counts.

## Test plan
- Reset then single request: `rst_n` low then high, `req` = 8'h08, `en` = 1.
  - Required: `gnt` = 8'h08, `gnt_idx` = 3, `gnt_vld` = 1 one cycle later.
  - After `req` = 0: `gnt` = 0 next cycle.
- Round-robin fairness: `req` = 8'hFF held, `MAX_HOLD` = 4.
  - Required grant sequence: indices 0,1,2,…,7,0.
  - Each grant lasts 4 cycles, separated by one zero cycle.
  - `gnt` is always one-hot or zero.
- Wrap-around: grant index 7, release, `req` = 8'b1000_0001.
  - Required: next grant is index 0, after exactly one gap cycle.
- Sole requester exceeds hold: `req` = 8'h20 held for 40 cycles, `MAX_HOLD` = 16.
  - Required: `gnt` = 8'h20 continuously, with no gap cycle.
- Enable drop: mid-grant, `en` = 0.
  - Required: `gnt` = 0 next cycle; no new grant while `en` = 0.
  - After `en` = 1 with `req` = 8'h05 and `ptr` = 3: grant index 0.
- Async reset mid-grant: `rst_n` pulsed low between clock edges during GRANT.
  - Required: `gnt` = 0 and `gnt_vld` = 0 immediately.
  - After release with `req` = 8'h90: grant index 4.
